// File: rtl/uart.sv
// Full-duplex 8N1 UART transceiver with a fixed baud rate.
// The transmitter fires whenever data_in differs from the last byte it sent.
// The receiver loads data_out only for frames that end in a valid stop bit.
module uart #(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF_CYC = BIT_CYC / 2;
   localparam int unsigned CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   logic [1:0]       tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic [7:0]       last_sent_q, last_sent_d;
   logic             tx_q, tx_d;

   logic             rx_meta_q, rx_sync_q;
   logic [1:0]       rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             armed_q, armed_d;
   logic [7:0]       data_out_q, data_out_d;

   assign tx       = tx_q;
   assign data_out = data_out_q;

   // Transmitter: start on a new data_in value, then hold each bit for BIT_CYC cycles
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      last_sent_d = last_sent_q;
      tx_d        = tx_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (data_in != last_sent_q) begin
               tx_shift_d  = data_in;
               last_sent_d = data_in;
               tx_d        = 1'b0;
               tx_cnt_d    = '0;
               tx_state_d  = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_d       = tx_shift_q[0];
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_d       = 1'b1;
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_d       = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            tx_d = 1'b1;
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   // Transmitter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         last_sent_q <= '0;
         tx_q        <= 1'b1;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         last_sent_q <= last_sent_d;
         tx_q        <= tx_d;
      end
   end

   // Receiver: mid-bit sampling; a bad stop bit disarms until the line is seen high
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      armed_d    = armed_q;
      data_out_d = data_out_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_sync_q) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               if (rx_sync_q) begin
                  data_out_d = rx_shift_q;
               end else begin
                  armed_d = 1'b0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   // Receiver registers; the synchroniser resets low so a tied-low line never arms
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q  <= 1'b0;
         rx_sync_q  <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         armed_q    <= 1'b0;
         data_out_q <= '0;
      end else begin
         rx_meta_q  <= rx;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         armed_q    <= armed_d;
         data_out_q <= data_out_d;
      end
   end

endmodule

// File: tb/tb_uart.sv
// Randomised bench for uart with a scaled-down bit period (16 cycles per bit).
// A frame-level model predicts which bytes leave on tx and what data_out holds.
module tb_uart;

   localparam int BIT = 16;
   localparam int FRAME = 10 * BIT;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_drv;
   logic       loop_en;
   logic       rx_w;
   logic       tx;
   logic [7:0] data_in;
   logic [7:0] data_out;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_byte[$];
   logic       got_ok[$];
   int         got_lead[$];
   logic [7:0] m_last;
   logic [7:0] m_dout;

   assign rx_w = loop_en ? tx : rx_drv;

   uart #(.CLK_FREQ(1600), .BAUD_RATE(100)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx_w),
      .tx(tx),
      .data_in(data_in),
      .data_out(data_out)
   );

   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Capture every tx frame as one sample per cycle, decode bits at mid-bit
   initial begin : tx_mon
      logic [FRAME-1:0] s;
      logic [7:0] b;
      logic ab;
      int n;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && tx === 1'b0) begin
            s = '0;
            ab = 1'b0;
            s[0] = tx;
            for (int i = 1; i < FRAME; i++) begin
               @(negedge clk);
               if (rst !== 1'b1) begin
                  ab = 1'b1;
                  break;
               end
               s[i] = tx;
            end
            if (!ab) begin
               for (int j = 0; j < 8; j++) b[j] = s[(j + 1) * BIT + BIT / 2];
               n = 0;
               while (n < FRAME && s[n] == 1'b0) n++;
               got_byte.push_back(b);
               got_ok.push_back(s[BIT / 2] == 1'b0 && s[9 * BIT + BIT / 2] == 1'b1);
               got_lead.push_back(n);
            end
         end
      end
   end

   // Model: tx sends the current data_in if it differs from the last byte sent
   task automatic model_sync();
      if (data_in != m_last) begin
         exp_q.push_back(data_in);
         m_last = data_in;
      end
   endtask

   task automatic expect_frames();
      logic [7:0] e;
      int w;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         w = 0;
         while (got_byte.size() == 0 && w < FRAME + 2 * BIT) begin
            @(negedge clk);
            w++;
         end
         if (got_byte.size() == 0) begin
            chk("tx_timeout", 32'd0, 32'd1);
         end else begin
            chk("tx_byte", {24'd0, got_byte.pop_front()}, {24'd0, e});
            chk("tx_framing", {31'd0, got_ok.pop_front()}, 32'd1);
            if (e[0]) chk("tx_start_len", got_lead.pop_front(), BIT);
            else void'(got_lead.pop_front());
         end
      end
   endtask

   task automatic expect_quiet(input int cyc);
      repeat (cyc) @(negedge clk);
      chk("tx_spurious", got_byte.size(), 32'd0);
      got_byte.delete();
      got_ok.delete();
      got_lead.delete();
   endtask

   function automatic logic [7:0] rand_diff(input logic [7:0] avoid);
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      while (v == avoid) v = 8'($urandom_range(0, 255));
      return v;
   endfunction

   // Loopback send: the received byte must match what went out
   task automatic send_loop(input logic [7:0] v);
      @(negedge clk);
      data_in = v;
      model_sync();
      expect_frames();
      m_dout = m_last;
      repeat (8) @(negedge clk);
      chk("loop_dout", {24'd0, data_out}, {24'd0, m_dout});
   endtask

   // data_in changes twice during a frame; only the value seen at idle counts
   task automatic mid_change(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      @(negedge clk);
      data_in = a;
      model_sync();
      repeat (40) @(negedge clk);
      data_in = b;
      repeat (40) @(negedge clk);
      data_in = c;
      model_sync();
      expect_frames();
      expect_quiet(2 * FRAME);
      m_dout = m_last;
      chk("mid_dout", {24'd0, data_out}, {24'd0, m_dout});
   endtask

   // Drive one serial frame on rx; stop bit value selectable
   task automatic send_rx(input logic [7:0] v, input logic stopv);
      @(negedge clk);
      rx_drv = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      rx_drv = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = v[i];
         repeat (BIT) @(negedge clk);
      end
      rx_drv = stopv;
      repeat (4) @(negedge clk);
      chk("rx_early", {24'd0, data_out}, {24'd0, m_dout});
      repeat (BIT - 4) @(negedge clk);
      rx_drv = 1'b1;
      if (stopv) m_dout = v;
      repeat (BIT) @(negedge clk);
      chk(stopv ? "rx_byte" : "rx_frame_err", {24'd0, data_out}, {24'd0, m_dout});
   endtask

   task automatic do_reset(input logic rxv);
      @(negedge clk);
      rst = 1'b0;
      rx_drv = rxv;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      m_last = 8'h00;
      m_dout = 8'h00;
      model_sync();
   endtask

   initial begin
      logic [7:0] v, a, b, c;
      rst = 1'b0;
      rx_drv = 1'b1;
      data_in = 8'h00;
      loop_en = 1'b0;
      m_last = 8'h00;
      m_dout = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_dout", {24'd0, data_out}, 32'd0);
      expect_quiet(3 * FRAME);

      // Loopback 0x12, 0x34, 0x56 with exact start latency on the first
      loop_en = 1'b1;
      @(negedge clk);
      data_in = 8'h12;
      @(posedge clk);
      #1 chk("tx_latency", {31'd0, tx}, 32'd0);
      model_sync();
      expect_frames();
      m_dout = m_last;
      repeat (8) @(negedge clk);
      chk("loop_dout", {24'd0, data_out}, 32'h12);
      send_loop(8'h34);
      send_loop(8'h56);

      mid_change(8'h34, 8'h56, 8'h78);
      for (int k = 0; k < 4; k++) begin
         a = rand_diff(m_last);
         b = 8'($urandom_range(0, 255));
         c = (k == 0) ? a : 8'($urandom_range(0, 255));
         mid_change(a, b, c);
      end
      for (int k = 0; k < 8; k++) send_loop(rand_diff(m_last));
      expect_quiet(FRAME);

      // Receiver alone: good frames, framing error, glitch, break
      loop_en = 1'b0;
      for (int k = 0; k < 5; k++) send_rx(8'($urandom_range(0, 255)), 1'b1);
      send_rx(rand_diff(m_dout), 1'b0);
      send_rx(8'($urandom_range(0, 255)), 1'b1);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      chk("rx_glitch", {24'd0, data_out}, {24'd0, m_dout});
      send_rx(rand_diff(m_dout), 1'b1);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (40 * BIT) @(negedge clk);
      chk("rx_break", {24'd0, data_out}, {24'd0, m_dout});
      send_rx(rand_diff(m_dout), 1'b1);

      // rx tied low out of reset never updates data_out
      do_reset(1'b0);
      expect_frames();
      repeat (2000) @(negedge clk);
      chk("rx_tied_low", {24'd0, data_out}, 32'd0);
      send_rx(8'hA5, 1'b1);

      // Reset in the middle of a tx frame
      loop_en = 1'b1;
      v = rand_diff(m_last);
      if (v == 8'h00) v = 8'h81;
      @(negedge clk);
      data_in = v;
      repeat (50) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 chk("rst_tx_async", {31'd0, tx}, 32'd1);
      chk("rst_dout", {24'd0, data_out}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      m_last = 8'h00;
      m_dout = 8'h00;
      model_sync();
      expect_frames();
      @(negedge clk);
      data_in = 8'h00;
      repeat (50) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 chk("rst_tx_async0", {31'd0, tx}, 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      m_last = 8'h00;
      model_sync();
      chk("rst_zero_pending", exp_q.size(), 32'd0);
      expect_quiet(3 * FRAME);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
